// File: rtl/match_ctrl_if.sv
// Signal bundle between the match sequencer and its environment: button,
// mover goal flags and frame strobe in; motion gating, score and status out.
interface match_ctrl_if;
  logic       frame_tick;
  logic       start;
  logic       goal1;
  logic       goal2;
  logic       mover_run;
  logic       puck_reset;
  logic       serve_dir;
  logic [2:0] score1;
  logic [2:0] score2;
  logic [1:0] winner;
  logic [2:0] state;

  modport slave (
    input  frame_tick, start, goal1, goal2,
    output mover_run, puck_reset, serve_dir, score1, score2, winner, state
  );

  modport master (
    output frame_tick, start, goal1, goal2,
    input  mover_run, puck_reset, serve_dir, score1, score2, winner, state
  );
endinterface

// File: rtl/match_ctrl.sv
// Air-hockey match sequencer: gates puck motion, times serve and post-goal
// freezes in frame ticks, keeps both scores and declares the winner.
module match_ctrl #(
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_FRAMES = 30,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic          clk,
  input  logic          clr,
  match_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [2:0] WIN3   = 3'(WIN_SCORE);
  localparam logic [7:0] SERVE8 = 8'(SERVE_FRAMES);
  localparam logic [7:0] PAUSE8 = 8'(PAUSE_FRAMES);

  state_t     state_r, state_s;
  logic [7:0] cnt_r, cnt_s;
  logic       start_q, goal1_q, goal2_q;
  logic       mover_run_r, mover_run_s;
  logic       puck_reset_r, puck_reset_s;
  logic       serve_dir_r, serve_dir_s;
  logic [2:0] score1_r, score1_s;
  logic [2:0] score2_r, score2_s;
  logic [1:0] winner_r, winner_s;
  logic       start_ev_s, g1_ev_s, g2_ev_s;

  assign start_ev_s = bus.start & ~start_q;
  assign g1_ev_s    = bus.goal1 & ~goal1_q;
  assign g2_ev_s    = bus.goal2 & ~goal2_q;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    puck_reset_s = 1'b0;
    serve_dir_s  = serve_dir_r;
    score1_s     = score1_r;
    score2_s     = score2_r;
    winner_s     = winner_r;
    case (state_r)
      IDLE, OVER: begin
        if (start_ev_s) begin
          score1_s     = 3'd0;
          score2_s     = 3'd0;
          winner_s     = 2'd0;
          serve_dir_s  = 1'b0;
          puck_reset_s = 1'b1;
          cnt_s        = SERVE8;
          state_s      = SERVE;
        end else begin
          state_s = state_r;
        end
      end
      SERVE: begin
        if (bus.frame_tick) begin
          if (cnt_r <= 8'd1) begin
            cnt_s   = 8'd0;
            state_s = PLAY;
          end else begin
            cnt_s = cnt_r - 8'd1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      PLAY: begin
        // A simultaneous right-goal edge is dropped when the left goal scores.
        if (g1_ev_s) begin
          score1_s    = score1_r + 3'd1;
          serve_dir_s = 1'b1;
          if (score1_s == WIN3) begin
            winner_s = 2'd1;
            state_s  = OVER;
          end else begin
            cnt_s   = PAUSE8;
            state_s = PAUSE;
          end
        end else if (g2_ev_s) begin
          score2_s    = score2_r + 3'd1;
          serve_dir_s = 1'b0;
          if (score2_s == WIN3) begin
            winner_s = 2'd2;
            state_s  = OVER;
          end else begin
            cnt_s   = PAUSE8;
            state_s = PAUSE;
          end
        end else begin
          state_s = PLAY;
        end
      end
      PAUSE: begin
        if (bus.frame_tick) begin
          if (cnt_r <= 8'd1) begin
            puck_reset_s = 1'b1;
            cnt_s        = SERVE8;
            state_s      = SERVE;
          end else begin
            cnt_s = cnt_r - 8'd1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s     = IDLE;
        cnt_s       = 8'd0;
        serve_dir_s = 1'b0;
        score1_s    = 3'd0;
        score2_s    = 3'd0;
        winner_s    = 2'd0;
      end
    endcase
    mover_run_s = (state_s == PLAY);
  end

  // State, counter, edge-detect history and output registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r      <= IDLE;
      cnt_r        <= 8'd0;
      start_q      <= 1'b0;
      goal1_q      <= 1'b0;
      goal2_q      <= 1'b0;
      mover_run_r  <= 1'b0;
      puck_reset_r <= 1'b0;
      serve_dir_r  <= 1'b0;
      score1_r     <= 3'd0;
      score2_r     <= 3'd0;
      winner_r     <= 2'd0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      start_q      <= bus.start;
      goal1_q      <= bus.goal1;
      goal2_q      <= bus.goal2;
      mover_run_r  <= mover_run_s;
      puck_reset_r <= puck_reset_s;
      serve_dir_r  <= serve_dir_s;
      score1_r     <= score1_s;
      score2_r     <= score2_s;
      winner_r     <= winner_s;
    end
  end

  assign bus.mover_run  = mover_run_r;
  assign bus.puck_reset = puck_reset_r;
  assign bus.serve_dir  = serve_dir_r;
  assign bus.score1     = score1_r;
  assign bus.score2     = score2_r;
  assign bus.winner     = winner_r;
  assign bus.state      = state_r;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed bench for match_ctrl with SERVE_FRAMES=3, PAUSE_FRAMES=4, WIN_SCORE=5.
module tb_match_ctrl;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int   checks = 0;
  int   errors = 0;

  match_ctrl_if mif ();

  match_ctrl #(.WIN_SCORE(5), .SERVE_FRAMES(3), .PAUSE_FRAMES(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (mif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      mif.frame_tick = 1'b1;
      cyc(1);
      mif.frame_tick = 1'b0;
      cyc(1);
    end
  endtask

  initial begin
    mif.frame_tick = 1'b0;
    mif.start      = 1'b0;
    mif.goal1      = 1'b0;
    mif.goal2      = 1'b0;
    cyc(2);
    clr = 1'b0;
    chk("rst_state", mif.state, 0);
    chk("rst_run", mif.mover_run, 0);
    chk("rst_preset", mif.puck_reset, 0);
    chk("rst_s1", mif.score1, 0);
    chk("rst_s2", mif.score2, 0);
    chk("rst_win", mif.winner, 0);
    chk("rst_dir", mif.serve_dir, 0);

    // start -> SERVE with a one-cycle puck_reset
    mif.start = 1'b1;
    cyc(1);
    chk("start_state", mif.state, 1);
    chk("start_preset", mif.puck_reset, 1);
    mif.start = 1'b0;
    cyc(1);
    chk("start_preset_off", mif.puck_reset, 0);
    tick(2);
    chk("serve_2tick", mif.state, 1);
    chk("serve_2tick_run", mif.mover_run, 0);
    tick(1);
    chk("serve_done", mif.state, 2);
    chk("serve_done_run", mif.mover_run, 1);

    // goal1 held 5 cycles counts once
    mif.goal1 = 1'b1;
    cyc(1);
    chk("g1_s1", mif.score1, 1);
    chk("g1_dir", mif.serve_dir, 1);
    chk("g1_state", mif.state, 3);
    chk("g1_run", mif.mover_run, 0);
    cyc(4);
    mif.goal1 = 1'b0;
    chk("g1_held", mif.score1, 1);
    cyc(1);

    // goal edge in PAUSE ignored
    mif.goal2 = 1'b1;
    cyc(1);
    mif.goal2 = 1'b0;
    cyc(1);
    chk("pause_g2_s2", mif.score2, 0);
    chk("pause_g2_state", mif.state, 3);

    tick(3);
    chk("pause_3tick", mif.state, 3);
    mif.frame_tick = 1'b1;
    cyc(1);
    mif.frame_tick = 1'b0;
    chk("pause_end_state", mif.state, 1);
    chk("pause_end_preset", mif.puck_reset, 1);
    cyc(1);
    chk("pause_end_preset_off", mif.puck_reset, 0);

    // goal edge in SERVE ignored
    mif.goal1 = 1'b1;
    cyc(1);
    mif.goal1 = 1'b0;
    cyc(1);
    chk("serve_g1_s1", mif.score1, 1);
    chk("serve_g1_state", mif.state, 1);
    tick(3);
    chk("serve2_done", mif.state, 2);

    // start in PLAY ignored
    mif.start = 1'b1;
    cyc(1);
    mif.start = 1'b0;
    cyc(1);
    chk("play_start_state", mif.state, 2);
    chk("play_start_s1", mif.score1, 1);

    // simultaneous goal edges: only goal1 counts
    mif.goal1 = 1'b1;
    mif.goal2 = 1'b1;
    cyc(1);
    mif.goal1 = 1'b0;
    mif.goal2 = 1'b0;
    chk("sim_s1", mif.score1, 2);
    chk("sim_s2", mif.score2, 0);
    chk("sim_state", mif.state, 3);
    cyc(1);

    // mid-match clear with cnt=2
    tick(2);
    chk("pre_clr_state", mif.state, 3);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr_state", mif.state, 0);
    chk("clr_s1", mif.score1, 0);
    chk("clr_dir", mif.serve_dir, 0);
    chk("clr_preset", mif.puck_reset, 0);
    cyc(1);
    chk("clr_preset_after", mif.puck_reset, 0);
    chk("clr_state_after", mif.state, 0);

    // new match; tick on the entry cycle is not counted
    mif.start = 1'b1;
    mif.frame_tick = 1'b1;
    cyc(1);
    mif.start = 1'b0;
    mif.frame_tick = 1'b0;
    chk("new_state", mif.state, 1);
    cyc(1);
    tick(2);
    chk("entry_tick_state", mif.state, 1);
    tick(1);
    chk("entry_tick_play", mif.state, 2);

    // player 2 scores four goals, then wins
    for (int k = 1; k <= 4; k++) begin
      mif.goal2 = 1'b1;
      mif.frame_tick = (k == 1);
      cyc(1);
      mif.goal2 = 1'b0;
      mif.frame_tick = 1'b0;
      chk("p2_score", mif.score2, k);
      chk("p2_dir", mif.serve_dir, 0);
      chk("p2_state", mif.state, 3);
      cyc(1);
      tick(3);
      chk("p2_pause_hold", mif.state, 3);
      tick(1);
      chk("p2_serve", mif.state, 1);
      tick(3);
      chk("p2_play", mif.state, 2);
    end
    mif.goal2 = 1'b1;
    cyc(1);
    mif.goal2 = 1'b0;
    chk("win_state", mif.state, 4);
    chk("win_winner", mif.winner, 2);
    chk("win_s2", mif.score2, 5);
    chk("win_run", mif.mover_run, 0);
    cyc(1);
    mif.goal1 = 1'b1;
    cyc(1);
    mif.goal1 = 1'b0;
    cyc(1);
    chk("over_s1", mif.score1, 0);
    chk("over_s2", mif.score2, 5);
    chk("over_state", mif.state, 4);

    // restart from OVER
    mif.start = 1'b1;
    cyc(1);
    mif.start = 1'b0;
    chk("restart_state", mif.state, 1);
    chk("restart_s2", mif.score2, 0);
    chk("restart_winner", mif.winner, 0);
    chk("restart_preset", mif.puck_reset, 1);
    cyc(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/match_ctrl.md
# match_ctrl

Match sequencer for the air-hockey game. It sits between the player start button, the puck mover's goal flags and the VGA/score display. It gates puck motion, requests puck re-centring and runs serve and post-goal countdowns in frame ticks. It also keeps both scores and declares the winner, so that match policy lives outside the motion datapath.

## Interface
- WIN_SCORE, 5: goals needed to win; 1..7.
- SERVE_FRAMES, 30: frame ticks the puck stays frozen before play; 1..255.
- PAUSE_FRAMES, 60: frame ticks of freeze after a goal; 1..255.
- clk  in  1  system clock; the only clock.
- clr  in  1  reset, synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per movement frame, the same strobe that advances the mover.
- start  in  1  debounced start button, level; the block edge-detects it.
- goal1  in  1  mover left-goal flag, level; may stay high for several cycles.
- goal2  in  1  mover right-goal flag, level.
- mover_run  out  1  high only in PLAY; gates the mover's position update.
- puck_reset  out  1  one-cycle pulse: mover re-centres the puck and zeroes its velocity.
- serve_dir  out  1  0 = serve toward right, 1 = serve toward left.
- score1  out  3  player-1 goals.
- score2  out  3  player-2 goals.
- winner  out  2  0 none, 1 player 1, 2 player 2.
- state  out  3  IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4 (debug/display).

## Operation
- Internal registers: start_q, goal1_q, goal2_q hold the previous cycle's inputs for rising-edge detection. cnt is an 8-bit frame counter.
- Event definitions:
  - start_ev = start & ~start_q.
  - g1_ev = goal1 & ~goal1_q.
  - g2_ev = goal2 & ~goal2_q.
- IDLE:
  - mover_run=0.
  - On start_ev: score1=score2=0, winner=0, serve_dir=0, pulse puck_reset, cnt=SERVE_FRAMES, go to SERVE.
- SERVE:
  - mover_run=0.
  - Each frame_tick decrements cnt.
  - A tick that takes cnt from 1 to 0 moves the block to PLAY on the next cycle.
- PLAY:
  - mover_run=1.
  - g1_ev: score1+1, serve_dir=1.
  - g2_ev: score2+1, serve_dir=0.
  - g1_ev and g2_ev in the same cycle: only g1_ev is counted; g2_ev is discarded.
  - After a goal, if the new score equals WIN_SCORE: winner = scoring player, go to OVER.
  - Otherwise: cnt=PAUSE_FRAMES, go to PAUSE.
- PAUSE:
  - mover_run=0.
  - cnt decrements on each frame_tick.
  - A tick that takes cnt from 1 to 0 pulses puck_reset, reloads cnt=SERVE_FRAMES and goes to SERVE.
- OVER:
  - mover_run=0; scores and winner hold.
  - start_ev behaves exactly as in IDLE (new match).
- Events outside their owning state are ignored and never queued:
  - goal edges outside PLAY;
  - start_ev in SERVE, PLAY or PAUSE.
- Scores never exceed WIN_SCORE and need no wrap handling. Width is 3 bits.
- Illegal state encodings (5–7) return to IDLE on the next clock with all outputs at reset values.

## Timing
- All outputs are registered. Reset values (clr high at a clk edge):
  - state=IDLE, mover_run=0, puck_reset=0, serve_dir=0;
  - score1=score2=0, winner=0;
  - cnt=0, start_q=goal1_q=goal2_q=0.
- clr has priority over every event in the same cycle. Asserting clr mid-match aborts it; no puck_reset is issued by clr.
- Edge detector latency:
  - start rising at cycle N → start_ev at N → state, scores and puck_reset update at edge N+1.
  - puck_reset is high for exactly one cycle.
- Goal latency:
  - goal1 rising at cycle N → score1 and state update at N+1.
  - mover_run falls at N+1, so the mover sees at most one further enabled cycle.
- Serve length:
  - Exactly SERVE_FRAMES frame_ticks after entering SERVE.
  - A frame_tick in the same cycle as SERVE entry is not counted, because cnt loads that cycle.
- Pause length: exactly PAUSE_FRAMES frame_ticks after entering PAUSE, under the same entry rule.
- frame_tick coinciding with a goal edge in PLAY: the goal is processed, and the tick is not counted toward the pause.
- goal1 held high across multiple cycles or frames yields one score increment. A new increment requires goal1 to fall and rise again.

## Test plan
- Reset then start: clr 2 cycles, start pulse → next cycle state=1, puck_reset one cycle, scores 0.
  - With SERVE_FRAMES=3: after exactly 3 frame_ticks, state=2 and mover_run=1.
- Single goal: in PLAY, goal1 held 5 cycles → score1=1 (not 5), serve_dir=1, state=3.
  - With PAUSE_FRAMES=4: after 4 ticks, puck_reset pulses and state=1.
- Simultaneous goals: g1 and g2 rise in the same cycle → score1=1, score2=0.
- Match win: drive player 2 to 5 goals (WIN_SCORE=5) → state=4, winner=2, score2=5, mover_run=0.
  - Further goal edges leave scores unchanged.
  - start_ev → scores 0, winner 0, state=1.
- Ignored events: goal edges in SERVE/PAUSE and start in PLAY → no score or state change.
- Mid-match reset: clr asserted in PAUSE with cnt=2 → next cycle all outputs at reset values, state=0; no puck_reset pulse.
